// File: rtl/snax_simd_out_packer_if.sv
// Stream/config bundle between the SIMD result stream, the CSR block and the streamer writer port.
// The slave modport is the packer's view; the master modport drives it.
interface snax_simd_out_packer_if #(
  parameter int unsigned InWidth   = 512,
  parameter int unsigned PackRatio = 4,
  parameter int unsigned CntWidth  = 32
) ();
  localparam int unsigned OutWidth = InWidth * PackRatio;

  logic [CntWidth-1:0] cfg_len_i;
  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [InWidth-1:0]  in_data_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [OutWidth-1:0] out_data_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                busy_o;
  logic [CntWidth-1:0] perf_cnt_o;

  modport slave (
    input  cfg_len_i, cfg_valid_i, in_data_i, in_valid_i, out_ready_i,
    output cfg_ready_o, in_ready_o, out_data_o, out_valid_o, busy_o, perf_cnt_o
  );

  modport master (
    output cfg_len_i, cfg_valid_i, in_data_i, in_valid_i, out_ready_i,
    input  cfg_ready_o, in_ready_o, out_data_o, out_valid_o, busy_o, perf_cnt_o
  );
endinterface

// File: rtl/snax_simd_out_packer.sv
// Packs PackRatio narrow SIMD result beats into one wide streamer word, zero-padding the tail word.
// Busy-cycle performance counter is present only when SNAX_SIMD_OUT_PACKER_PERF_EN is defined.
module snax_simd_out_packer #(
  parameter int unsigned InWidth   = 512,
  parameter int unsigned PackRatio = 4,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  snax_simd_out_packer_if.slave  bus
);
  localparam int unsigned OutWidth = InWidth * PackRatio;
  localparam int unsigned LaneW    = $clog2(PackRatio);

  if ((PackRatio < 2) || ((PackRatio & (PackRatio - 1)) != 0)) begin : g_bad_ratio
    $error("PackRatio must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [OutWidth-1:0] lanes_q, lanes_d;
  logic [OutWidth-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [LaneW-1:0]    lane_idx_q, lane_idx_d;
  logic [CntWidth-1:0] remaining_q, remaining_d;

  logic [OutWidth-1:0] packed_word;
  logic                cfg_start;
  logic                out_fire;
  logic                last_beat;
  logic                completing;
  logic                cfg_ready;
  logic                in_ready;

  assign cfg_start  = (state_q == IDLE) && bus.cfg_valid_i && (bus.cfg_len_i != '0);
  assign out_fire   = out_valid_q && bus.out_ready_i;
  assign last_beat  = (remaining_q == CntWidth'(1));
  assign completing = (lane_idx_q == LaneW'(PackRatio - 1)) || last_beat;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    state_d     = state_q;
    lanes_d     = lanes_q;
    lane_idx_d  = lane_idx_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;

    packed_word = lanes_q;
    packed_word[lane_idx_q*InWidth +: InWidth] = bus.in_data_i;

    // A handshake retires the word; a completing beat below may reload it in the same cycle.
    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          remaining_d = bus.cfg_len_i;
          lane_idx_d  = '0;
          lanes_d     = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        in_ready = completing ? (!out_valid_q || bus.out_ready_i) : 1'b1;
        if (bus.in_valid_i && in_ready) begin
          remaining_d = remaining_q - 1'b1;
          if (completing) begin
            out_data_d  = packed_word;
            out_valid_d = 1'b1;
            lanes_d     = '0;
            lane_idx_d  = '0;
          end else begin
            lanes_d    = packed_word;
            lane_idx_d = lane_idx_q + 1'b1;
          end
          if (last_beat) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the data registers are reset too, so an aborted transfer never leaks a stale word.
      lanes_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      lane_idx_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      lane_idx_q  <= lane_idx_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef SNAX_SIMD_OUT_PACKER_PERF_EN
  logic [CntWidth-1:0] perf_q, perf_d;

  // Saturating busy-cycle count; held through IDLE so CSRs can read the last transfer.
  always_comb begin
    perf_d = perf_q;
    if (cfg_start) begin
      perf_d = '0;
    end else if ((state_q != IDLE) && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cnt_o = perf_q;
`else
  assign bus.perf_cnt_o = '0;
`endif

  assign bus.cfg_ready_o = cfg_ready;
  assign bus.in_ready_o  = in_ready;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule
